// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces switches/buttons, emits press pulses,
// change strobe and a snapshot of the clean input word with an acknowledge handshake.
module input_conditioner #(
   parameter int DEB_CYCLES = 50000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  CH,
   input  logic [3:0]  BT,
   output logic [7:0]  SW,
   output logic [3:0]  BTN,
   output logic [3:0]  BTP,
   output logic        CHG,
   output logic [11:0] SNAP,
   output logic        SNAP_VLD,
   input  logic        SNAP_ACK,
   output logic        OVR
);
   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
   localparam logic [11:0] IDLE = 12'hF00;
   logic [11:0] s1, s2, stable, flip, nxt;
   logic [CW-1:0] cnt [12];
   // a bit flips when it has disagreed with its stable value for the full window
   always_comb begin
      flip = '0;
      for (int i = 0; i < 12; i++) flip[i] = (s2[i] != stable[i]) && (cnt[i] == LAST);
   end
   assign nxt = stable ^ flip;
   assign SW = stable[7:0];
   assign BTN = stable[11:8];
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1 <= IDLE;
         s2 <= IDLE;
         stable <= IDLE;
         for (int i = 0; i < 12; i++) cnt[i] <= '0;
         BTP <= '0;
         CHG <= 1'b0;
         SNAP <= IDLE;
         SNAP_VLD <= 1'b0;
         OVR <= 1'b0;
      end else begin
         s1 <= {BT, CH};
         s2 <= s1;
         stable <= nxt;
         for (int i = 0; i < 12; i++) cnt[i] <= (s2[i] == stable[i] || flip[i]) ? '0 : cnt[i] + CW'(1);
         BTP <= stable[11:8] & ~nxt[11:8];
         CHG <= |flip;
         // a same-edge acknowledge consumes the old word, so no overrun is flagged
         if (|flip) begin
            SNAP <= nxt;
            SNAP_VLD <= 1'b1;
            OVR <= SNAP_VLD & ~SNAP_ACK;
         end else if (SNAP_ACK && SNAP_VLD) begin
            SNAP_VLD <= 1'b0;
            OVR <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed vectors with hand-computed expectations, DEB_CYCLES=4.
module tb_input_conditioner;
   logic clk = 1'b0, rst = 1'b1, ack = 1'b0;
   logic [7:0] ch = 8'h00, sw;
   logic [3:0] bt = 4'hF, btn, btp;
   logic chg, vld, ovr;
   logic [11:0] snap;
   int checks = 0, failures = 0;

   input_conditioner #(.DEB_CYCLES(4)) dut (
      .CLK(clk), .RST(rst), .CH(ch), .BT(bt), .SW(sw), .BTN(btn), .BTP(btp), .CHG(chg),
      .SNAP(snap), .SNAP_VLD(vld), .SNAP_ACK(ack), .OVR(ovr)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   initial begin
      tick(2);
      check("rst_sw", sw, 8'h00);
      check("rst_btn", btn, 4'hF);
      check("rst_snap", snap, 12'hF00);
      check("rst_vld", vld, 0);
      check("rst_ovr", ovr, 0);
      check("rst_btp", btp, 0);
      check("rst_chg", chg, 0);
      rst = 1'b0;
      tick(2);
      // CH7 rises
      ch = 8'h80;
      tick(5);
      check("ch7_early", sw, 8'h00);
      check("ch7_early_chg", chg, 0);
      tick();
      check("ch7_sw", sw, 8'h80);
      check("ch7_chg", chg, 1);
      check("ch7_snap", snap, 12'hF80);
      check("ch7_vld", vld, 1);
      tick();
      check("ch7_chg_once", chg, 0);
      do_ack();
      check("ack_vld", vld, 0);
      check("ack_snap_hold", snap, 12'hF80);
      do_ack();
      check("ack_idle_vld", vld, 0);
      // BT3 glitch shorter than the window
      bt = 4'h7;
      tick(3);
      bt = 4'hF;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("glitch_btn", btn, 4'hF);
         check("glitch_chg", chg, 0);
         check("glitch_btp", btp, 0);
      end
      bt = 4'h7;
      tick(6);
      check("bt3_btn", btn, 4'h7);
      check("bt3_btp", btp, 4'h8);
      check("bt3_chg", chg, 1);
      check("bt3_snap", snap, 12'h780);
      bt = 4'hF;
      tick(6);
      check("bt3_rel_btn", btn, 4'hF);
      check("bt3_rel_btp", btp, 0);
      check("bt3_rel_snap", snap, 12'hF80);
      check("bt3_rel_ovr", ovr, 1);
      do_ack();
      check("ack2_vld", vld, 0);
      check("ack2_ovr", ovr, 0);
      // BT0 held 20 cycles
      bt = 4'hE;
      tick(5);
      check("bt0_early", btn, 4'hF);
      tick();
      check("bt0_btn", btn, 4'hE);
      check("bt0_btp", btp, 4'h1);
      check("bt0_chg", chg, 1);
      check("bt0_snap", snap, 12'hE80);
      for (int i = 0; i < 14; i++) begin
         tick();
         check("bt0_hold_btp", btp, 0);
         check("bt0_hold_btn", btn, 4'hE);
      end
      bt = 4'hF;
      tick(6);
      check("bt0_rel_btn", btn, 4'hF);
      check("bt0_rel_chg", chg, 1);
      check("bt0_rel_btp", btp, 0);
      do_ack();
      ch = 8'h00;
      tick(6);
      check("ch7_fall", sw, 8'h00);
      do_ack();
      // two changes without acknowledge
      ch = 8'h01;
      tick(6);
      check("ch0_snap", snap, 12'hF01);
      check("ch0_ovr", ovr, 0);
      ch = 8'h03;
      tick(6);
      check("ch1_snap", snap, 12'hF03);
      check("ch1_vld", vld, 1);
      check("ch1_ovr", ovr, 1);
      tick(3);
      check("snap_stable", snap, 12'hF03);
      do_ack();
      check("ack3_vld", vld, 0);
      check("ack3_ovr", ovr, 0);
      // acknowledge on the same edge as a change
      ch = 8'h07;
      tick(6);
      check("ch2_vld", vld, 1);
      ch = 8'h0F;
      tick(5);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("same_snap", snap, 12'hF0F);
      check("same_vld", vld, 1);
      check("same_ovr", ovr, 0);
      do_ack();
      // reset in the middle of a count on CH4
      ch = 8'h1F;
      tick(4);
      rst = 1'b1;
      tick();
      check("mid_sw", sw, 8'h00);
      check("mid_btn", btn, 4'hF);
      check("mid_snap", snap, 12'hF00);
      check("mid_vld", vld, 0);
      check("mid_chg", chg, 0);
      rst = 1'b0;
      tick(5);
      check("post_early", sw, 8'h00);
      tick();
      check("post_sw", sw, 8'h1F);
      check("post_chg", chg, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
